// File: rtl/reg_scoreboard_if.sv
// Decode <-> scoreboard bundle: issue request, two source queries, and the hazard/busy view returned.
// Decode drives the master side; the scoreboard answers combinationally on the slave side.
interface reg_scoreboard_if #(
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG),
  parameter int CW   = 3
);
  logic               stall;
  logic               flush_decode;
  logic               issue_valid;
  logic [AW-1:0]      issue_adr;
  logic [CW-1:0]      issue_lat;
  logic [AW-1:0]      rs_adr0;
  logic [AW-1:0]      rs_adr1;
  logic               hazard0;
  logic               hazard1;
  logic [NREG-1:0]    register_busy;
  logic [NREG*CW-1:0] cnt_flat;
  logic               any_busy;

  modport master (
    output stall, flush_decode, issue_valid, issue_adr, issue_lat, rs_adr0, rs_adr1,
    input  hazard0, hazard1, register_busy, cnt_flat, any_busy
  );

  modport slave (
    input  stall, flush_decode, issue_valid, issue_adr, issue_lat, rs_adr0, rs_adr1,
    output hazard0, hazard1, register_busy, cnt_flat, any_busy
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: one latency down-counter per register; queries are combinational on current state,
// stall freezes everything. SCOREBOARD_FWD_EN: a counter of 1 is covered by the bypass network and is not a hazard.
module reg_scoreboard #(
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG),
  parameter int CW   = 3
) (
  input logic              clk,
  input logic              reset,
  reg_scoreboard_if.slave  sb
);

  logic [CW-1:0] cnt     [NREG];
  logic [CW-1:0] cnt_nxt [NREG];
  logic          adr_in_range;
  logic          issue_ok;
  logic          hz0;
  logic          hz1;
  logic [NREG-1:0]    busy;
  logic [NREG*CW-1:0] flat;

  function automatic logic pending(input logic [CW-1:0] c);
`ifdef SCOREBOARD_FWD_EN
    return c > CW'(1);
`else
    return c != '0;
`endif
  endfunction

  assign adr_in_range = ({1'b0, sb.issue_adr} < (AW+1)'(NREG));
  assign issue_ok     = sb.issue_valid && !sb.flush_decode && !sb.stall &&
                        (sb.issue_lat != '0) && adr_in_range;

  // A younger write only ever extends the wait (WAW merge takes the larger of the two).
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt[i] = cnt[i];
      if (!sb.stall) begin
        cnt_nxt[i] = (cnt[i] == '0) ? '0 : cnt[i] - 1'b1;
        if (issue_ok && (sb.issue_adr == AW'(i)) && (sb.issue_lat > cnt_nxt[i])) begin
          cnt_nxt[i] = sb.issue_lat;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (reset) begin
        cnt[i] <= '0;
      end else begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // Address decode by loop so an out-of-range query simply matches nothing.
  always_comb begin
    hz0  = 1'b0;
    hz1  = 1'b0;
    busy = '0;
    flat = '0;
    for (int i = 0; i < NREG; i++) begin
      busy[i]          = (cnt[i] != '0);
      flat[i*CW +: CW] = cnt[i];
      if (sb.rs_adr0 == AW'(i)) hz0 = pending(cnt[i]);
      if (sb.rs_adr1 == AW'(i)) hz1 = pending(cnt[i]);
    end
  end

  assign sb.hazard0       = hz0;
  assign sb.hazard1       = hz1;
  assign sb.register_busy = busy;
  assign sb.cnt_flat      = flat;
  assign sb.any_busy      = |busy;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed plan plus random traffic against a ready-time model.
module tb_reg_scoreboard;
  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int CW   = 3;

  logic clk;
  logic reset;

  reg_scoreboard_if #(.NREG(NREG), .AW(AW), .CW(CW)) sb_if ();

  reg_scoreboard #(.NREG(NREG), .AW(AW), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Model: each register is ready at an absolute point on the unstalled-cycle timeline.
  longint u = 0;
  longint ready [NREG];
  bit     armed = 0;

  function automatic int mcnt(input int r);
    return (ready[r] > u) ? int'(ready[r] - u) : 0;
  endfunction

  function automatic bit mpend(input int r);
`ifdef SCOREBOARD_FWD_EN
    return mcnt(r) > 1;
`else
    return mcnt(r) != 0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input int r, input int exp);
    check($sformatf("cnt[%0d]", r), 32'(sb_if.cnt_flat[r*CW +: CW]), 32'(exp));
  endtask

  task automatic check_all(input string tag);
    logic [NREG*CW-1:0] eflat;
    logic [NREG-1:0]    ebusy;
    eflat = '0;
    ebusy = '0;
    for (int r = 0; r < NREG; r++) begin
      eflat[r*CW +: CW] = CW'(mcnt(r));
      ebusy[r]          = (mcnt(r) != 0);
    end
    check({tag, ".cnt_flat"}, 32'(sb_if.cnt_flat), 32'(eflat));
    check({tag, ".busy"},     32'(sb_if.register_busy), 32'(ebusy));
    check({tag, ".any_busy"}, 32'(sb_if.any_busy), 32'(ebusy != '0));
    check({tag, ".hazard0"},  32'(sb_if.hazard0), 32'(mpend(int'(sb_if.rs_adr0))));
    check({tag, ".hazard1"},  32'(sb_if.hazard1), 32'(mpend(int'(sb_if.rs_adr1))));
  endtask

  // One clock: drive, check pre-edge state at negedge, advance model at posedge.
  task automatic step(input string tag, input bit v, input int adr, input int lat,
                      input bit st, input bit fl, input int r0, input int r1, input bit rst);
    longint tgt;
    reset              = rst;
    sb_if.issue_valid  = v;
    sb_if.issue_adr    = AW'(adr);
    sb_if.issue_lat    = CW'(lat);
    sb_if.stall        = st;
    sb_if.flush_decode = fl;
    sb_if.rs_adr0      = AW'(r0);
    sb_if.rs_adr1      = AW'(r1);
    @(negedge clk);
    if (armed) check_all(tag);
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREG; r++) ready[r] = u;
      armed = 1;
    end else if (!st) begin
      u++;
      if (v && !fl && lat != 0) begin
        tgt = u + lat;
        if (tgt > ready[adr]) ready[adr] = tgt;
      end
    end
    #1;
  endtask

  task automatic idle(input int r0);
    step("idle", 0, 0, 0, 0, 0, r0, 0, 0);
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) ready[r] = 0;
    step("rst", 0, 0, 0, 0, 0, 0, 0, 1);
    step("rst", 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) idle(0);
    for (int r = 0; r < NREG; r++) check_cnt(r, 0);

    // Basic latency with query on the same register
    step("iss3", 1, 3, 2, 0, 0, 3, 3, 0);
    check_cnt(3, 2);
    idle(3); check_cnt(3, 1);
    idle(3); check_cnt(3, 0);
    idle(3);

    // WAW merge
    step("iss5a", 1, 5, 5, 0, 0, 5, 0, 0); check_cnt(5, 5);
    step("iss5b", 1, 5, 1, 0, 0, 5, 0, 0); check_cnt(5, 4);
    for (int k = 0; k < 3; k++) idle(5);
    check_cnt(5, 1);
    idle(5); check_cnt(5, 0);
    step("iss2a", 1, 2, 4, 0, 0, 2, 5, 0);
    idle(2); idle(2); check_cnt(2, 2);
    step("iss2b", 1, 2, 7, 0, 0, 2, 5, 0); check_cnt(2, 7);
    for (int k = 0; k < 7; k++) idle(2);
    check_cnt(2, 0);

    // Stall freeze and blocked issue
    step("iss1", 1, 1, 3, 0, 0, 1, 2, 0); check_cnt(1, 3);
    for (int k = 0; k < 4; k++) step("stall", 1, 2, 5, 1, 0, 1, 2, 0);
    check_cnt(1, 3); check_cnt(2, 0);
    idle(1); check_cnt(1, 2);
    idle(1); check_cnt(1, 1);
    idle(1); check_cnt(1, 0);

    // Flush suppresses issue, in-flight counter keeps going
    step("iss6", 1, 6, 3, 0, 0, 6, 4, 0);
    idle(6); check_cnt(6, 2);
    step("flush", 1, 4, 3, 0, 1, 6, 4, 0);
    check_cnt(4, 0); check_cnt(6, 1);
    idle(6);

    // Reset with counters in flight
    step("iss0", 1, 0, 3, 0, 0, 0, 7, 0);
    step("iss7", 1, 7, 6, 0, 0, 0, 7, 0);
    step("rstmid", 0, 0, 0, 0, 0, 0, 7, 1);
    for (int r = 0; r < NREG; r++) check_cnt(r, 0);
    check("any_busy_after_rst", 32'(sb_if.any_busy), 32'd0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step("rnd",
           $urandom_range(0, 1) == 1,
           int'($urandom_range(0, NREG - 1)),
           int'($urandom_range(0, 7)),
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0,
           int'($urandom_range(0, NREG - 1)),
           int'($urandom_range(0, NREG - 1)),
           $urandom_range(0, 99) == 0);
    end
    idle(0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
